// File: rtl/fetch_stage_pkg.sv
// Shared core package: IF/ID bundle, fetch FSM states, reset PC.
// FETCH_MISALIGN_TRAP_EN adds the exception fields and the HALT state.
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        FS_BOOT = 2'd0,
        FS_RUN  = 2'd1
    } fetch_state_e;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic        valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        logic        exc_valid;
        logic [31:0] exc_tval;
`endif
    } if_id_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC mux and boot/run FSM.
// FETCH_MISALIGN_TRAP_EN: misaligned redirect targets park the stage in HALT.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_en_o,
    output if_id_t      fetch_o
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redir_pc;
    logic         w_valid;
    logic         w_en;
    logic         w_exc;

    assign w_pc_plus4 = r_pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = |redirect_pc_i[1:0];
    assign w_redir_pc = redirect_pc_i;
`else
    assign w_redir_pc = {redirect_pc_i[31:2], 2'b00};
`endif

    // State and PC register; reset beats every other input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= FS_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state, next PC and per-state outputs; redirect overrides stall.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid     = 1'b0;
        w_en        = 1'b0;
        w_exc       = 1'b0;
        unique case (r_state)
            FS_BOOT: begin
                w_state_nxt = FS_RUN;
            end
            FS_RUN: begin
                w_en    = !stall_i && !redirect_i;
                w_valid = !redirect_i;
                if (!stall_i) begin
                    w_pc_nxt = w_pc_plus4;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FS_HALT: begin
                w_valid = !redirect_i;
                w_exc   = !redirect_i;
            end
`endif
            default: begin
                w_state_nxt = FS_BOOT;
            end
        endcase
        if (redirect_i) begin
            w_pc_nxt    = w_redir_pc;
            w_state_nxt = FS_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_misalign) begin
                w_state_nxt = FS_HALT;
            end
`endif
        end
        if (!rst_n) begin
            w_valid = 1'b0;
            w_en    = 1'b0;
            w_exc   = 1'b0;
        end
    end

    // Outputs are a pure function of the PC register and FSM decode.
    always_comb begin
        fetch_o          = '0;
        fetch_o.pc       = r_pc;
        fetch_o.pc_plus4 = w_pc_plus4;
        fetch_o.valid    = w_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_o.exc_valid = w_exc;
        fetch_o.exc_tval  = w_exc ? r_pc : 32'd0;
`endif
    end

    assign imem_addr_o = r_pc;
    assign imem_en_o   = w_en;

`ifndef FETCH_MISALIGN_TRAP_EN
    logic w_unused;
    assign w_unused = w_exc ^ redirect_pc_i[1] ^ redirect_pc_i[0];
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed test of fetch_stage: reset bubble, stall, redirect, wrap,
// reset priority and (when enabled) misaligned-target HALT.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic        imem_en_o;
    if_id_t      fetch_o;

    int n_chk;
    int n_fail;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_addr_o   (imem_addr_o),
        .imem_en_o     (imem_en_o),
        .fetch_o       (fetch_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to the middle of the next cycle and apply inputs.
    task automatic drive(input logic rst, input logic st, input logic rd,
                         input logic [31:0] tgt);
        @(negedge clk);
        rst_n         = rst;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = tgt;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc,
                           input logic v, input logic en);
        chk({tag, ".pc"}, fetch_o.pc, pc);
        chk({tag, ".addr"}, imem_addr_o, pc);
        chk({tag, ".p4"}, fetch_o.pc_plus4, pc + 32'd4);
        chk({tag, ".valid"}, {31'd0, fetch_o.valid}, {31'd0, v});
        chk({tag, ".en"}, {31'd0, imem_en_o}, {31'd0, en});
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'd0;

        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk_out("in_reset", 32'h0, 1'b0, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("boot", 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run0", 32'h0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run4", 32'h4, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run8", 32'h8, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("runC", 32'hC, 1'b1, 1'b1);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 32'd0);
            chk_out("stall10", 32'h10, 1'b1, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("unstall10", 32'h10, 1'b1, 1'b1);
        for (int a = 32'h14; a <= 32'h3C; a += 4) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0);
            chk("walk.pc", fetch_o.pc, a);
        end

        drive(1'b1, 1'b1, 1'b1, 32'h200);
        chk_out("redir_stall40", 32'h40, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("tgt200", 32'h200, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run204", 32'h204, 1'b1, 1'b1);

        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        chk_out("redir_wrap", 32'h208, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("wrapF8", 32'hFFFF_FFF8, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("wrapFC", 32'hFFFF_FFFC, 1'b1, 1'b1);
        chk("wrapFC.p4_zero", fetch_o.pc_plus4, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("wrap00", 32'h0, 1'b1, 1'b1);
        chk("wrap00.p4", fetch_o.pc_plus4, 32'h4);

`ifndef FETCH_MISALIGN_TRAP_EN
        drive(1'b1, 1'b0, 1'b1, 32'h107);
        chk_out("redir_mis", 32'h4, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("mis_forced", 32'h104, 1'b1, 1'b1);
`endif

        drive(1'b1, 1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 32'h500);
        chk("rst_stall.valid", {31'd0, fetch_o.valid}, 32'd0);
        chk("rst_stall.en", {31'd0, imem_en_o}, 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'h80);
        chk_out("boot_redir", 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("boot_tgt80", 32'h80, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run84", 32'h84, 1'b1, 1'b1);

`ifdef FETCH_MISALIGN_TRAP_EN
        drive(1'b1, 1'b0, 1'b1, 32'h102);
        chk_out("redir102", 32'h88, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("halt", 32'h102, 1'b1, 1'b0);
        chk("halt.exc", {31'd0, fetch_o.exc_valid}, 32'd1);
        chk("halt.tval", fetch_o.exc_tval, 32'h102);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        chk_out("halt_stall", 32'h102, 1'b1, 1'b0);
        chk("halt_stall.tval", fetch_o.exc_tval, 32'h102);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("halt_hold", 32'h102, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h300);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("run300", 32'h300, 1'b1, 1'b1);
        chk("run300.exc", {31'd0, fetch_o.exc_valid}, 32'd0);

        drive(1'b1, 1'b0, 1'b1, 32'h102);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("halt_rst", 32'h0, 1'b0, 1'b0);
        chk("halt_rst.exc", {31'd0, fetch_o.exc_valid}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        chk_out("halt_rst_run", 32'h0, 1'b1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the byte address fetched first after reset.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port stall_i, input, 1: hazard-unit stall; hold PC and BRAM output.
REQ-005 SHALL have port redirect_i, input, 1: branch/jump/trap redirect from execute.
REQ-006 SHALL have port redirect_pc_i, input, 32: redirect target byte address.
REQ-007 SHALL have port imem_addr_o, output, 32: instruction BRAM byte address (1-cycle read latency).
REQ-008 SHALL have port imem_en_o, output, 1: BRAM read enable; when low, BRAM data output holds.
REQ-009 SHALL have port fetch_o, output, if_id_t: pc, pc_plus4, valid (and exception fields per REQ-024) to the IF/ID register input.

Function
REQ-010 SHALL hold a PC register pc_q and drive imem_addr_o = pc_q, fetch_o.pc = pc_q, fetch_o.pc_plus4 = pc_q + 32'd4 (modulo 2^32), combinationally from pc_q.
REQ-011 SHALL implement FSM states BOOT, RUN, and (macro only) HALT.
REQ-012 BOOT: fetch_o.valid=0, imem_en_o=0, pc_q unchanged; next state RUN unconditionally (one bubble after reset).
REQ-013 RUN: imem_en_o = !stall_i && !redirect_i; fetch_o.valid = !redirect_i.
REQ-014 Next-PC priority: redirect_i -> pc_q <= {redirect_pc_i[31:2],2'b00} (full value with macro); else stall_i -> hold; else RUN -> pc_q + 4.
REQ-015 Redirect SHALL override a simultaneous stall_i; the wrong-path fetch of the redirect cycle SHALL be marked valid=0.
REQ-016 First valid fetch after a redirect SHALL appear in the cycle after redirect_i, at the redirect target.
REQ-017 During stall_i without redirect, pc_q, fetch_o, and imem_en_o=0 SHALL stay stable so the held IF/ID contents and held BRAM data remain aligned.
REQ-018 PC increment SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-019 Redirect received in BOOT SHALL load pc_q and still transition to RUN.

Reset
REQ-020 While rst_n=0 at a clock edge: pc_q <= RESET_PC, state <= BOOT, HALT cleared.
REQ-021 Outputs during and one cycle after reset: fetch_o.valid=0, imem_en_o=0, imem_addr_o=RESET_PC.
REQ-022 Reset asserted mid-stall or mid-redirect SHALL take priority over all other inputs.

Configuration
REQ-023 Macro FETCH_MISALIGN_TRAP_EN SHALL select misaligned-target trapping.
REQ-024 Defined: if_id_t gains exc_valid (1) and exc_tval (32); redirect with redirect_pc_i[1:0]!=0 loads full target, enters HALT; HALT drives valid=1, exc_valid=1, exc_tval=pc_q, imem_en_o=0, PC held; exits to RUN only on a new redirect; stall_i holds HALT outputs.
REQ-025 Undefined: redirect_pc_i[1:0] ignored (forced 00), HALT unreachable, no exception fields.

Structure
REQ-026 if_id_t, fetch state enum, and RESET_PC default constant SHALL live in the shared core package, exception fields guarded by the same macro.
REQ-027 No sub-module; next-PC mux, PC register, and FSM in one module.

Verification
REQ-028 Reset release, RESET_PC=0 -> cycle 1 valid=0, imem_en_o=0; then pc 0x0, 0x4, 0x8 on consecutive cycles, valid=1.
REQ-029 Stall 3 cycles at pc=0x10 -> pc, fetch_o held at 0x10, imem_en_o=0; next cycle pc=0x14.
REQ-030 redirect_i with target 0x200 while stall_i=1 at pc=0x40 -> that cycle valid=0, imem_en_o=0; next cycle pc=0x200, valid=1.
REQ-031 Free-run from pc=0xFFFF_FFF8 -> 0xFFFF_FFFC then 0x0000_0000, pc_plus4 of last = 0x4.
REQ-032 Macro on: redirect to 0x102 -> next cycle HALT, exc_valid=1, exc_tval=0x102, imem_en_o=0; redirect 0x300 -> RUN, pc=0x300, exc_valid=0.
REQ-033 rst_n low during HALT (macro on) or mid-stall -> next cycle BOOT, pc=RESET_PC, valid=0.
